reg_arbiter: RTL and testbench

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/reg_arbiter.sv | 127 ++++++++++++
 tb/tb_reg_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_arbiter.sv
// ============================================================================
//  Module      : reg_arbiter
//  Description : Four-requester round-robin arbiter guarding a shared register,
//                with per-requester lock and synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [3:0]     lock,
    input  logic [4*W-1:0] wdata,
    input  logic           clr,
    output logic [3:0]     gnt,
    output logic [W-1:0]   q,
    output logic [1:0]     owner,
    output logic           locked
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     lo_q, lo_d;
    logic [1:0]     owner_q, owner_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [W-1:0]   data_q, data_d;

    logic [W-1:0]   w_slice [4];
    logic           w_win_vld;
    logic [1:0]     w_win_idx;
    logic [1:0]     w_cand;

    for (genvar i = 0; i < 4; i++) begin : g_slice
        assign w_slice[i] = wdata[W*i +: W];
    end

    // First requesting index at or after ptr, wrapping modulo 4.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        w_cand    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_cand = ptr_q + k[1:0];
            if (!w_win_vld && req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lo_d    = lo_q;
        owner_d = owner_q;
        data_d  = data_q;
        gnt_d   = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    data_d = '0;
                end else if (w_win_vld) begin
                    data_d  = w_slice[w_win_idx];
                    owner_d = w_win_idx;
                    gnt_d   = 4'b0001 << w_win_idx;
                    if (lock[w_win_idx]) begin
                        state_d = S_LOCKED;
                        lo_d    = w_win_idx;
                    end else begin
                        ptr_d = w_win_idx + 2'd1;
                    end
                end
            end
            S_LOCKED: begin
                if (clr) begin
                    data_d = '0;
                end else if (req[lo_q]) begin
                    data_d  = w_slice[lo_q];
                    owner_d = lo_q;
                    gnt_d   = 4'b0001 << lo_q;
                end
                // Releasing the lock hands priority to the requester after the owner.
                if (!lock[lo_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = lo_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            lo_q    <= 2'd0;
            owner_q <= 2'd0;
            gnt_q   <= 4'b0000;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lo_q    <= lo_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
        end
    end

    assign gnt    = gnt_q;
    assign q      = data_q;
    assign owner  = owner_q;
    assign locked = (state_q == S_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_reg_arbiter.sv
// ============================================================================
//  Module      : tb_reg_arbiter
//  Description : Vector-table and scoreboard bench for reg_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_arbiter;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [3:0]     req;
    logic [3:0]     lock;
    logic [4*W-1:0] wdata;
    logic           clr;
    logic [3:0]     gnt;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           locked;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] wdata;
        logic        clr;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        locked;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       locked;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[20];

    reg_arbiter #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .clr    (clr),
        .gnt    (gnt),
        .q      (q),
        .owner  (owner),
        .locked (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    task automatic chk_outputs(input exp_t e);
        chk("gnt",    e.id, 32'(gnt),    32'(e.gnt));
        chk("q",      e.id, 32'(q),      32'(e.q));
        chk("owner",  e.id, 32'(owner),  32'(e.owner));
        chk("locked", e.id, 32'(locked), 32'(e.locked));
    endtask

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] lk, input logic [31:0] wd,
                                input logic cl, input logic [3:0] g, input logic [7:0] qq,
                                input logic [1:0] ow, input logic lo);
        vec_t v;
        v.req = rq; v.lock = lk; v.wdata = wd; v.clr = cl;
        v.gnt = g; v.q = qq; v.owner = ow; v.locked = lo;
        return v;
    endfunction

    // Drive one vector, queue its expectation, and compare after the edge.
    task automatic run_vec(input int id, input vec_t v);
        exp_t e;
        req   = v.req;
        lock  = v.lock;
        wdata = v.wdata;
        clr   = v.clr;
        e.id = id; e.gnt = v.gnt; e.q = v.q; e.owner = v.owner; e.locked = v.locked;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", id, 32'd0, 32'd1);
        end else begin
            chk_outputs(sb.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        z.gnt = 4'b0; z.q = 8'h00; z.owner = 2'd0; z.locked = 1'b0;

        vecs[0]  = mk(4'b1111, 4'b0000, 32'h44332211, 1'b0, 4'b0001, 8'h11, 2'd0, 1'b0);
        vecs[1]  = mk(4'b1111, 4'b0000, 32'h44332211, 1'b0, 4'b0010, 8'h22, 2'd1, 1'b0);
        vecs[2]  = mk(4'b1111, 4'b0000, 32'h44332211, 1'b0, 4'b0100, 8'h33, 2'd2, 1'b0);
        vecs[3]  = mk(4'b1111, 4'b0000, 32'h44332211, 1'b0, 4'b1000, 8'h44, 2'd3, 1'b0);
        vecs[4]  = mk(4'b0000, 4'b0000, 32'h44332211, 1'b0, 4'b0000, 8'h44, 2'd3, 1'b0);
        vecs[5]  = mk(4'b1000, 4'b0000, 32'hA0332211, 1'b0, 4'b1000, 8'hA0, 2'd3, 1'b0);
        vecs[6]  = mk(4'b1000, 4'b0000, 32'hA1332211, 1'b0, 4'b1000, 8'hA1, 2'd3, 1'b0);
        vecs[7]  = mk(4'b1000, 4'b0000, 32'hA2332211, 1'b0, 4'b1000, 8'hA2, 2'd3, 1'b0);
        vecs[8]  = mk(4'b0001, 4'b0000, 32'h443322A5, 1'b0, 4'b0001, 8'hA5, 2'd0, 1'b0);
        vecs[9]  = mk(4'b0011, 4'b0000, 32'h44332211, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0);
        vecs[10] = mk(4'b0011, 4'b0000, 32'h44332211, 1'b0, 4'b0010, 8'h22, 2'd1, 1'b0);
        vecs[11] = mk(4'b0100, 4'b0000, 32'h44332211, 1'b0, 4'b0100, 8'h33, 2'd2, 1'b0);
        vecs[12] = mk(4'b1000, 4'b0000, 32'h44332211, 1'b0, 4'b1000, 8'h44, 2'd3, 1'b0);
        vecs[13] = mk(4'b0101, 4'b0100, 32'h44332211, 1'b0, 4'b0001, 8'h11, 2'd0, 1'b0);
        vecs[14] = mk(4'b0101, 4'b0100, 32'h44332211, 1'b0, 4'b0100, 8'h33, 2'd2, 1'b1);
        vecs[15] = mk(4'b0101, 4'b0100, 32'h443C2211, 1'b0, 4'b0100, 8'h3C, 2'd2, 1'b1);
        vecs[16] = mk(4'b0001, 4'b0100, 32'h44332211, 1'b0, 4'b0000, 8'h3C, 2'd2, 1'b1);
        vecs[17] = mk(4'b0101, 4'b0100, 32'h44332211, 1'b0, 4'b0100, 8'h33, 2'd2, 1'b1);
        vecs[18] = mk(4'b0101, 4'b0000, 32'h44332211, 1'b0, 4'b0100, 8'h33, 2'd2, 1'b0);
        vecs[19] = mk(4'b0101, 4'b0000, 32'h44332211, 1'b0, 4'b0001, 8'h11, 2'd0, 1'b0);

        rst = 1'b0; req = '0; lock = '0; wdata = '0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        z.id = -1;
        chk_outputs(z);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_vec(i, vecs[i]);
        end

        // Enter LOCKED with q=5A, then reset between edges while gnt is high.
        run_vec(20, mk(4'b0010, 4'b0010, 32'h44335A11, 1'b0, 4'b0010, 8'h5A, 2'd1, 1'b1));
        run_vec(21, mk(4'b0010, 4'b0010, 32'h44335A11, 1'b0, 4'b0010, 8'h5A, 2'd1, 1'b1));
        #2;
        rst = 1'b0;
        #1;
        z.id = 22;
        chk_outputs(z);
        @(posedge clk);
        #1;
        z.id = 23;
        chk_outputs(z);
        rst = 1'b1;
        run_vec(24, mk(4'b0010, 4'b0000, 32'h44332211, 1'b0, 4'b0010, 8'h22, 2'd1, 1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
